// File: rtl/pc_redirect_fetch_stage.sv
// IF-stage PC register plus IF/ID pipeline register with ID-stage redirect,
// wrong-path squash, stall hold, sticky misalignment flag and redirect counter.
module pc_redirect_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_decision,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      pc_out,
    output logic [31:0]      if_id_pc4,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4        = pc_out + 32'd4;
    assign redirect_target = jump ? jump_target : branch_target;
    assign flush           = (state == RUN) & ~stall & (jump | branch_decision);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc_out         <= RESET_PC;
            if_id_pc4      <= '0;
            if_id_instr    <= '0;
            if_id_valid    <= 1'b0;
            misalign_err   <= 1'b0;
            redirect_count <= '0;
        end else begin
            state <= RUN;
            if (state == BOOT || (!stall && !flush)) begin
                pc_out      <= pc_plus4;
                if_id_pc4   <= pc_plus4;
                if_id_instr <= imem_instr;
                if_id_valid <= 1'b1;
            end else if (flush) begin
                // Target is word-aligned on load; raw low bits only feed the sticky flag.
                pc_out      <= {redirect_target[31:2], 2'b00};
                if_id_pc4   <= '0;
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
                if (redirect_target[1:0] != 2'b00)
                    misalign_err <= 1'b1;
                if (redirect_count != '1)
                    redirect_count <= redirect_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_fetch_stage.sv
// Bench for pc_redirect_fetch_stage: directed vector table, hand sequences for
// misalign stickiness and mid-op reset, then random stimulus against a model.
module tb_pc_redirect_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_decision, jump;
    logic [31:0] branch_target, jump_target, imem_instr;
    logic [31:0] pc_out, if_id_pc4, if_id_instr;
    logic        if_id_valid, flush, misalign_err;
    logic [15:0] redirect_count;
    logic [31:0] s_pc, s_pc4, s_instr, s_imem;
    logic        s_valid, s_flush, s_mis;
    logic [1:0]  s_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    assign imem_instr = imem_fn(pc_out);
    assign s_imem     = imem_fn(s_pc);

    pc_redirect_fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_decision(branch_decision),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .imem_instr(imem_instr), .pc_out(pc_out), .if_id_pc4(if_id_pc4),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .flush(flush),
        .misalign_err(misalign_err), .redirect_count(redirect_count)
    );

    pc_redirect_fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_decision(branch_decision),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .imem_instr(s_imem), .pc_out(s_pc), .if_id_pc4(s_pc4),
        .if_id_instr(s_instr), .if_id_valid(s_valid), .flush(s_flush),
        .misalign_err(s_mis), .redirect_count(s_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        st, br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_pc4;
        int          e_cnt;
        int          e_sat;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic ef,
                                input logic [31:0] ep, input logic ev, input logic [31:0] ep4,
                                input int ec, input int es, input logic em);
        vec_t v;
        v.st = st; v.br = br; v.bt = bt; v.j = j; v.jt = jt; v.e_flush = ef;
        v.e_pc = ep; v.e_valid = ev; v.e_pc4 = ep4; v.e_cnt = ec; v.e_sat = es; v.e_mis = em;
        return v;
    endfunction

    // Behavioural reference: architectural fetch state only.
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid, m_mis, m_boot;
    int          m_cnt;

    task automatic model_reset();
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        m_mis = 1'b0; m_boot = 1'b1; m_cnt = 0;
    endtask

    function automatic logic model_redirects();
        return !m_boot && !stall && (jump || branch_decision);
    endfunction

    task automatic model_edge();
        logic [31:0] t;
        longint      nxt;
        if (model_redirects()) begin
            t = jump ? jump_target : branch_target;
            if (t % 4 != 0) m_mis = 1'b1;
            m_pc = t - (t % 4);
            m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt++;
        end else if (m_boot || !stall) begin
            nxt = (longint'(m_pc) + 4) % (longint'(1) << 32);
            m_instr = imem_fn(m_pc);
            m_pc = nxt[31:0];
            m_pc4 = nxt[31:0];
            m_valid = 1'b1;
        end
        m_boot = 1'b0;
    endtask

    task automatic compare_all();
        chk("pc_out", pc_out, m_pc);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("redirect_count", {16'b0, redirect_count}, m_cnt);
        chk("sat_count", {30'b0, s_count}, (m_cnt > 3) ? 3 : m_cnt);
    endtask

    task automatic rstep(input logic st, input logic br, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        stall = st; branch_decision = br; branch_target = bt; jump = j; jump_target = jt;
        #1;
        chk("flush_model", {31'b0, flush}, {31'b0, model_redirects()});
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_decision = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;

        // T1 reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_cnt", {16'b0, redirect_count}, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'h0);
        rst_n = 1'b1;

        //          st br bt            j  jt            fl pc            v  pc4           cnt sat mis
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h4,       1, 32'h4,       0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h8,       1, 32'h8,       0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'hC,       1, 32'hC,       0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h10,      1, 32'h10,      0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h40,      0, 32'h0,       1, 32'h40,      0, 32'h0,       1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h44,      1, 32'h44,      1, 1, 0));
        vecs.push_back(mk(1, 1, 32'h80,      0, 32'h0,       0, 32'h44,      1, 32'h44,      1, 1, 0));
        vecs.push_back(mk(1, 1, 32'h80,      0, 32'h0,       0, 32'h44,      1, 32'h44,      1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h80,      0, 32'h0,       1, 32'h80,      0, 32'h0,       2, 2, 0));
        vecs.push_back(mk(0, 1, 32'h300,     1, 32'h200,     1, 32'h200,     0, 32'h0,       3, 3, 0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h205,     1, 32'h204,     0, 32'h0,       4, 3, 1));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h208,     1, 32'h208,     4, 3, 1));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,   5, 3, 1));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       1, 32'h0,       5, 3, 1));

        foreach (vecs[i]) begin
            stall = vecs[i].st; branch_decision = vecs[i].br; branch_target = vecs[i].bt;
            jump = vecs[i].j; jump_target = vecs[i].jt;
            #1;
            chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].e_flush});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid)
                chk($sformatf("v%0d_pc4", i), if_id_pc4, vecs[i].e_pc4);
            else
                chk($sformatf("v%0d_nop", i), if_id_instr, 32'h0);
            chk($sformatf("v%0d_cnt", i), {16'b0, redirect_count}, vecs[i].e_cnt);
            chk($sformatf("v%0d_sat", i), {30'b0, s_count}, vecs[i].e_sat);
            chk($sformatf("v%0d_mis", i), {31'b0, misalign_err}, {31'b0, vecs[i].e_mis});
        end

        // misalign_err must stay set through idle cycles
        stall = 0; branch_decision = 0; jump = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("mis_sticky", {31'b0, misalign_err}, 32'h1);

        // T6 mid-op reset with a jump pending
        jump = 1'b1; jump_target = 32'h300;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc_out, 32'h0);
        chk("midrst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("midrst_mis", {31'b0, misalign_err}, 32'h0);
        chk("midrst_cnt", {16'b0, redirect_count}, 32'h0);
        #1;
        rst_n = 1'b1;
        model_reset();
        rstep(1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        chk("boot_no_redirect", pc_out, 32'h4);

        // random phase against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] bt, jt;
            bt = $urandom;
            jt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            if ($urandom_range(0, 3) != 0) begin
                bt[1:0] = 2'b00;
                jt[1:0] = 2'b00;
            end
            rstep($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, bt,
                  $urandom_range(0, 9) == 0, jt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
